// File: rtl/mem_access_if.sv
// Data-bus interface between the memory-access stage (master) and the data
// memory / bus slave. One request is in flight at a time; ack completes it and
// carries the read word in the same cycle.
interface mem_access_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 30
);
   logic                    req;
   logic                    we;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH/8-1:0] be;
   logic [DATA_WIDTH-1:0]   wdata;
   logic                    ack;
   logic [DATA_WIDTH-1:0]   rdata;

   modport master (
      output req, we, addr, be, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one load/store per instruction on the
// req/ack data bus, aligns and extends load data, and registers the
// write-back value, write enable and register address. Stalls the pipeline
// while a bus transaction is outstanding. If a load is acked while the rest
// of the pipeline is stalled, the read word is parked in a hold buffer so the
// access is never re-issued.
// Optional bus timeout: define MEM_BUS_TIMEOUT_EN to abort a WAIT that sees no
// ack within TIMEOUT_CYCLES cycles.
module mem_access #(
   parameter int DATA_WIDTH      = 32,
   parameter int DATA_ADDR_WIDTH = 30,
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic                       i_clk,
   input  logic                       i_arst_n,
   input  logic                       i_stall_en,
   input  logic [DATA_WIDTH-1:0]      i_alu_result,
   input  logic [DATA_WIDTH-1:0]      i_dout_b,
   input  logic                       i_dw_en_ex,
   input  logic                       i_dr_en_ex,
   input  logic [1:0]                 i_dsrs_out_ex,
   input  logic [2:0]                 i_dsel_width_ex,
   input  logic                       i_rw_en_ex,
   input  logic [REG_ADDR_WIDTH-1:0]  i_raddr_w_ex,
   output logic                       o_bus_req,
   output logic                       o_bus_we,
   output logic [DATA_ADDR_WIDTH-1:0] o_bus_addr,
   output logic [DATA_WIDTH/8-1:0]    o_bus_be,
   output logic [DATA_WIDTH-1:0]      o_bus_wdata,
   input  logic                       i_bus_ack,
   input  logic [DATA_WIDTH-1:0]      i_bus_rdata,
   output logic [DATA_WIDTH-1:0]      o_result_mem,
   output logic                       o_rw_en_mem,
   output logic [REG_ADDR_WIDTH-1:0]  o_raddr_w_mem,
   output logic                       o_stall_en_mem,
   output logic                       o_bus_timeout
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t                     state;
   logic [DATA_WIDTH-1:0]      hold_buf;
   logic                       mem_op;
   logic                       en;
   logic                       is_byte;
   logic                       is_half;
   logic                       is_signed;
   logic                       req;
   logic                       stall;
   logic                       commit;
   logic                       tmo_hit;
   logic [3:0]                 be;
   logic [DATA_WIDTH-1:0]      wdata;
   logic [DATA_WIDTH-1:0]      load_word;
   logic [DATA_WIDTH-1:0]      shifted;
   logic [DATA_WIDTH-1:0]      load_data;
   logic [DATA_ADDR_WIDTH-1:0] word_addr;

   assign mem_op    = i_dw_en_ex | i_dr_en_ex;
   assign en        = ~i_stall_en;
   assign is_byte   = (i_dsel_width_ex == 3'b010) | (i_dsel_width_ex == 3'b110);
   assign is_half   = (i_dsel_width_ex == 3'b001) | (i_dsel_width_ex == 3'b101);
   assign is_signed = ~i_dsel_width_ex[2];
   assign word_addr = i_alu_result[DATA_ADDR_WIDTH+1:2];

   // Byte enables and lane-replicated store data from the access width
   always_comb begin
      be    = 4'b1111;
      wdata = i_dout_b;
      if (is_byte) begin
         be    = 4'b0001 << i_alu_result[1:0];
         wdata = {4{i_dout_b[7:0]}};
      end else if (is_half) begin
         be    = i_alu_result[1] ? 4'b1100 : 4'b0011;
         wdata = {2{i_dout_b[15:0]}};
      end
   end

   // Load alignment: bring the addressed lane down to bit 0, then extend
   always_comb begin
      load_word = (state == S_HOLD) ? hold_buf : i_bus_rdata;
      shifted   = load_word;
      load_data = load_word;
      if (is_byte) begin
         shifted   = load_word >> {i_alu_result[1:0], 3'b000};
         load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      end else if (is_half) begin
         shifted   = load_word >> {i_alu_result[1], 4'b0000};
         load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      end
   end

   // Request, stall and commit decisions for the current state; reset drops req at once
   always_comb begin
      req    = 1'b0;
      stall  = 1'b0;
      commit = 1'b0;
      case (state)
         S_IDLE: begin
            req    = mem_op;
            stall  = mem_op & ~i_bus_ack;
            commit = en & (~mem_op | i_bus_ack);
         end
         S_WAIT: begin
            req    = 1'b1;
            stall  = ~i_bus_ack & ~tmo_hit;
            commit = en & i_bus_ack;
         end
         S_HOLD: begin
            commit = en;
         end
         default: begin
            req    = 1'b0;
         end
      endcase
      if (!i_arst_n) begin
         req   = 1'b0;
         stall = 1'b0;
      end
   end

   assign o_bus_req      = req;
   assign o_bus_we       = req & i_dw_en_ex;
   assign o_bus_addr     = word_addr;
   assign o_bus_be       = be;
   assign o_bus_wdata    = wdata;
   assign o_stall_en_mem = stall;

`ifdef MEM_BUS_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] tmo_cnt;
   logic             timeout_q;

   assign tmo_hit       = (state == S_WAIT) & ~i_bus_ack & (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign o_bus_timeout = timeout_q;

   // WAIT-cycle counter, cleared on entry to WAIT, plus the one-cycle abort pulse
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         tmo_cnt   <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= tmo_hit;
         if (state == S_IDLE && mem_op && !i_bus_ack) begin
            tmo_cnt <= '0;
         end else if (state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end
   end
`else
   assign tmo_hit       = 1'b0;
   assign o_bus_timeout = 1'b0;
`endif

   // FSM, hold buffer and registered write-back outputs
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state         <= S_IDLE;
         hold_buf      <= '0;
         o_result_mem  <= '0;
         o_rw_en_mem   <= 1'b0;
         o_raddr_w_mem <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (mem_op && i_bus_ack && !en) begin
                  hold_buf <= i_bus_rdata;
                  state    <= S_HOLD;
               end else if (mem_op && !i_bus_ack) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_bus_ack) begin
                  if (en) begin
                     state <= S_IDLE;
                  end else begin
                     hold_buf <= i_bus_rdata;
                     state    <= S_HOLD;
                  end
               end else if (tmo_hit) begin
                  state <= S_IDLE;
               end
            end
            S_HOLD: begin
               if (en) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         if (commit) begin
            o_result_mem  <= (i_dsrs_out_ex == 2'b01) ? load_data : i_alu_result;
            o_rw_en_mem   <= i_rw_en_ex;
            o_raddr_w_mem <= i_raddr_w_ex;
         end else if (tmo_hit) begin
            o_result_mem  <= '0;
            o_rw_en_mem   <= 1'b0;
            o_raddr_w_mem <= i_raddr_w_ex;
         end
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: a table of zero-wait-state accesses,
// then hand-written sequences for waited loads, the HOLD path, reset during
// WAIT and (with MEM_BUS_TIMEOUT_EN) the bus timeout. Expected write-back
// values go into a scoreboard queue when an instruction is driven and are
// popped when the stage commits it.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        stall_en;
   logic [31:0] alu_result;
   logic [31:0] dout_b;
   logic        dw_en;
   logic        dr_en;
   logic [1:0]  dsrs;
   logic [2:0]  sel_width;
   logic        rw_en;
   logic [4:0]  raddr_w;
   logic        bus_req;
   logic        bus_we;
   logic [29:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic [31:0] result_mem;
   logic        rw_en_mem;
   logic [4:0]  raddr_w_mem;
   logic        stall_mem;
   logic        bus_timeout;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] b;
      logic [31:0] rdata;
      logic        dw;
      logic        dr;
      logic [1:0]  dsrs;
      logic [2:0]  sel;
      logic        rw;
      logic [4:0]  raddr;
      logic [29:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_result;
   } vec_t;

   typedef struct {
      logic [31:0] result;
      logic        rw;
      logic [4:0]  raddr;
   } exp_t;

   vec_t vecs[13];
   exp_t sb[$];
   exp_t last_exp;

   mem_access #(.TIMEOUT_CYCLES(4)) dut (
      .i_clk           (clk),
      .i_arst_n        (arst_n),
      .i_stall_en      (stall_en),
      .i_alu_result    (alu_result),
      .i_dout_b        (dout_b),
      .i_dw_en_ex      (dw_en),
      .i_dr_en_ex      (dr_en),
      .i_dsrs_out_ex   (dsrs),
      .i_dsel_width_ex (sel_width),
      .i_rw_en_ex      (rw_en),
      .i_raddr_w_ex    (raddr_w),
      .o_bus_req       (bus_req),
      .o_bus_we        (bus_we),
      .o_bus_addr      (bus_addr),
      .o_bus_be        (bus_be),
      .o_bus_wdata     (bus_wdata),
      .i_bus_ack       (bus_ack),
      .i_bus_rdata     (bus_rdata),
      .o_result_mem    (result_mem),
      .o_rw_en_mem     (rw_en_mem),
      .o_raddr_w_mem   (raddr_w_mem),
      .o_stall_en_mem  (stall_mem),
      .o_bus_timeout   (bus_timeout)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Overall time bound so a stuck run still ends with a report
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input logic ack);
      alu_result    = v.alu;
      dout_b        = v.b;
      bus_rdata     = v.rdata;
      dw_en         = v.dw;
      dr_en         = v.dr;
      dsrs          = v.dsrs;
      sel_width     = v.sel;
      rw_en         = v.rw;
      raddr_w       = v.raddr;
      bus_ack       = ack;
   endtask

   task automatic pushExpect(input logic [31:0] res, input logic rw, input logic [4:0] ra);
      exp_t e;
      e.result = res;
      e.rw     = rw;
      e.raddr  = ra;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s_sb_empty actual=commit required=expectation", tag);
      end else begin
         e = sb.pop_front();
         check({tag, "_result"}, result_mem, e.result);
         check({tag, "_rw_en"}, {31'd0, rw_en_mem}, {31'd0, e.rw});
         check({tag, "_raddr"}, {27'd0, raddr_w_mem}, {27'd0, e.raddr});
         last_exp = e;
      end
   endtask

   task automatic idleBus();
      dw_en   = 1'b0;
      dr_en   = 1'b0;
      bus_ack = 1'b0;
   endtask

   // Load from 0x103 acked in the fourth cycle: three stall cycles expected
   task automatic waitedLoad(input logic [2:0] sel, input logic [31:0] exp_res, input string tag);
      vec_t v;
      int   stall_cycles;
      v = '{32'h103, 32'h0, 32'h80123456, 1'b0, 1'b1, 2'b01, sel, 1'b1, 5'd7,
            30'h40, 4'h8, 32'h0, exp_res};
      stall_cycles = 0;
      @(negedge clk);
      applyStimulus(v, 1'b0);
      pushExpect(exp_res, 1'b1, 5'd7);
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         bus_ack = (c == 3);
         #2;
         if (stall_mem) stall_cycles++;
         check({tag, "_req"}, {31'd0, bus_req}, 32'd1);
         @(posedge clk);
         #1;
      end
      checkOutput(tag);
      check({tag, "_stall_cycles"}, stall_cycles, 32'd3);
      check({tag, "_timeout"}, {31'd0, bus_timeout}, 32'd0);
      @(negedge clk);
      idleBus();
   endtask

   initial begin
      int req_cycles;
      int pulses;

      // field order: alu, b, rdata, dw, dr, dsrs, sel, rw, raddr, exp_addr, exp_be, exp_wdata, exp_result
      vecs[0]  = '{32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 2'b01, 3'b000, 1'b1, 5'd3, 30'h40, 4'hF, 32'h0, 32'hDEADBEEF};
      vecs[1]  = '{32'h103, 32'h0, 32'h80123456, 1'b0, 1'b1, 2'b01, 3'b010, 1'b1, 5'd4, 30'h40, 4'h8, 32'h0, 32'hFFFFFF80};
      vecs[2]  = '{32'h103, 32'h0, 32'h80123456, 1'b0, 1'b1, 2'b01, 3'b110, 1'b1, 5'd5, 30'h40, 4'h8, 32'h0, 32'h00000080};
      vecs[3]  = '{32'h102, 32'h0, 32'h80123456, 1'b0, 1'b1, 2'b01, 3'b001, 1'b1, 5'd6, 30'h40, 4'hC, 32'h0, 32'hFFFF8012};
      vecs[4]  = '{32'h100, 32'h0, 32'h80123456, 1'b0, 1'b1, 2'b01, 3'b101, 1'b1, 5'd7, 30'h40, 4'h3, 32'h0, 32'h00003456};
      vecs[5]  = '{32'h101, 32'h0, 32'h80123456, 1'b0, 1'b1, 2'b01, 3'b010, 1'b1, 5'd8, 30'h40, 4'h2, 32'h0, 32'h00000034};
      vecs[6]  = '{32'h102, 32'h0, 32'h80C15678, 1'b0, 1'b1, 2'b01, 3'b110, 1'b1, 5'd9, 30'h40, 4'h4, 32'h0, 32'h000000C1};
      vecs[7]  = '{32'h22, 32'h0000ABCD, 32'h0, 1'b1, 1'b0, 2'b00, 3'b001, 1'b0, 5'd10, 30'h8, 4'hC, 32'hABCDABCD, 32'h22};
      vecs[8]  = '{32'h1, 32'h123456EF, 32'h0, 1'b1, 1'b0, 2'b00, 3'b110, 1'b0, 5'd0, 30'h0, 4'h2, 32'hEFEFEFEF, 32'h1};
      vecs[9]  = '{32'h1FC, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 5'd11, 30'h7F, 4'hF, 32'hCAFEF00D, 32'h1FC};
      vecs[10] = '{32'h12345678, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 5'd31, 30'h0, 4'h0, 32'h0, 32'h12345678};
      vecs[11] = '{32'hA5A5A5A5, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 3'b000, 1'b1, 5'd17, 30'h0, 4'h0, 32'h0, 32'hA5A5A5A5};
      vecs[12] = '{32'h104, 32'h0, 32'h11223344, 1'b0, 1'b1, 2'b01, 3'b011, 1'b1, 5'd1, 30'h41, 4'hF, 32'h0, 32'h11223344};

      arst_n     = 1'b0;
      stall_en   = 1'b0;
      alu_result = 32'h0;
      dout_b     = 32'h0;
      dsrs       = 2'b00;
      sel_width  = 3'b000;
      rw_en      = 1'b0;
      raddr_w    = 5'd0;
      bus_rdata  = 32'h0;
      idleBus();

      #3;
      check("rst_result", result_mem, 32'h0);
      check("rst_rw_en", {31'd0, rw_en_mem}, 32'd0);
      check("rst_raddr", {27'd0, raddr_w_mem}, 32'd0);
      check("rst_req", {31'd0, bus_req}, 32'd0);
      check("rst_timeout", {31'd0, bus_timeout}, 32'd0);
      @(negedge clk);
      arst_n = 1'b1;

      // Zero-wait-state accesses and plain ALU ops from the table
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i], 1'b1);
         pushExpect(vecs[i].exp_result, vecs[i].rw, vecs[i].raddr);
         #2;
         check($sformatf("v%0d_req", i), {31'd0, bus_req}, {31'd0, vecs[i].dw | vecs[i].dr});
         check($sformatf("v%0d_stall", i), {31'd0, stall_mem}, 32'd0);
         if (vecs[i].dw | vecs[i].dr) begin
            check($sformatf("v%0d_addr", i), {2'b00, bus_addr}, {2'b00, vecs[i].exp_addr});
            check($sformatf("v%0d_be", i), {28'd0, bus_be}, {28'd0, vecs[i].exp_be});
            check($sformatf("v%0d_we", i), {31'd0, bus_we}, {31'd0, vecs[i].dw});
         end
         if (vecs[i].dw) begin
            check($sformatf("v%0d_wdata", i), bus_wdata, vecs[i].exp_wdata);
         end
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d", i));
      end
      @(negedge clk);
      idleBus();

      // Waited byte loads, signed then unsigned
      waitedLoad(3'b010, 32'hFFFFFF80, "wait_sb");
      waitedLoad(3'b110, 32'h00000080, "wait_ub");

      // Load acked under a global stall: parked in HOLD, committed once the stall drops
      req_cycles = 0;
      @(negedge clk);
      applyStimulus('{32'h200, 32'h0, 32'h0BADF00D, 1'b0, 1'b1, 2'b01, 3'b000, 1'b1, 5'd9,
                      30'h80, 4'hF, 32'h0, 32'h0BADF00D}, 1'b1);
      stall_en = 1'b1;
      #2;
      if (bus_req) req_cycles++;
      check("hold_stall_ack", {31'd0, stall_mem}, 32'd0);
      @(posedge clk);
      #1;
      check("hold_keep0", result_mem, last_exp.result);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         bus_ack   = 1'b0;
         bus_rdata = 32'hFFFFFFFF;
         #2;
         if (bus_req) req_cycles++;
         check($sformatf("hold_req%0d", c), {31'd0, bus_req}, 32'd0);
         check($sformatf("hold_stall%0d", c), {31'd0, stall_mem}, 32'd0);
         @(posedge clk);
         #1;
         check($sformatf("hold_keep_res%0d", c), result_mem, last_exp.result);
         check($sformatf("hold_keep_ra%0d", c), {27'd0, raddr_w_mem}, {27'd0, last_exp.raddr});
      end
      @(negedge clk);
      stall_en = 1'b0;
      pushExpect(32'h0BADF00D, 1'b1, 5'd9);
      #2;
      if (bus_req) req_cycles++;
      @(posedge clk);
      #1;
      checkOutput("hold_commit");
      check("hold_req_count", req_cycles, 32'd1);
      @(negedge clk);
      idleBus();

      // Reset asserted mid-WAIT while the request inputs are still up
      @(negedge clk);
      applyStimulus('{32'h300, 32'h0, 32'h0, 1'b0, 1'b1, 2'b01, 3'b000, 1'b1, 5'd4,
                      30'hC0, 4'hF, 32'h0, 32'h0}, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #2;
      check("rstw_req_before", {31'd0, bus_req}, 32'd1);
      arst_n = 1'b0;
      #1;
      check("rstw_req", {31'd0, bus_req}, 32'd0);
      check("rstw_stall", {31'd0, stall_mem}, 32'd0);
      check("rstw_result", result_mem, 32'h0);
      check("rstw_rw_en", {31'd0, rw_en_mem}, 32'd0);
      check("rstw_raddr", {27'd0, raddr_w_mem}, 32'd0);
      @(negedge clk);
      arst_n = 1'b1;
      applyStimulus('{32'h5, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 5'd2,
                      30'h0, 4'h0, 32'h0, 32'h5}, 1'b0);
      pushExpect(32'h5, 1'b1, 5'd2);
      #2;
      check("rstw_alu_req", {31'd0, bus_req}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("rstw_alu");

`ifdef MEM_BUS_TIMEOUT_EN
      // Load that is never acked: abort after four WAIT cycles
      pulses = 0;
      @(negedge clk);
      applyStimulus('{32'h400, 32'h0, 32'h0, 1'b0, 1'b1, 2'b01, 3'b000, 1'b1, 5'd12,
                      30'h100, 4'hF, 32'h0, 32'h0}, 1'b0);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (bus_timeout) begin
            pulses++;
            check("tmo_edge", c, 32'd4);
            check("tmo_rw_en", {31'd0, rw_en_mem}, 32'd0);
            check("tmo_result", result_mem, 32'h0);
            @(negedge clk);
            idleBus();
            #2;
            check("tmo_req_drop", {31'd0, bus_req}, 32'd0);
         end
      end
      check("tmo_pulses", pulses, 32'd1);
`else
      pulses = 0;
      check("no_tmo", {31'd0, bus_timeout}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
